// File: rtl/udc_bus_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : udc_pkg
//  Purpose  : Shared register addresses, failure codes and sequencer states
//             for the up/down-counter bus sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package udc_pkg;

    localparam logic [1:0] ADDR_PLR = 2'b00;
    localparam logic [1:0] ADDR_ULR = 2'b01;
    localparam logic [1:0] ADDR_LLR = 2'b10;
    localparam logic [1:0] ADDR_CCR = 2'b11;

    localparam int c_TIMER_W = 20;

    typedef enum logic [2:0] {
        FC_NONE     = 3'd0,
        FC_RANGE    = 3'd1,
        FC_READBACK = 3'd2,
        FC_COUNTER  = 3'd3,
        FC_TIMEOUT  = 3'd4
    } fail_code_t;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CHECK     = 4'd1,
        ST_WR_SETUP  = 4'd2,
        ST_WR_STROBE = 4'd3,
        ST_WR_HOLD   = 4'd4,
        ST_RD_STROBE = 4'd5,
        ST_RD_SAMPLE = 4'd6,
        ST_START     = 4'd7,
        ST_RUN       = 4'd8,
        ST_FAIL      = 4'd9
    } state_t;

endpackage
`default_nettype wire

// File: rtl/udc_bus_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : udc_bus_sequencer_if
//  Purpose  : Register bus and run-control signals between the sequencer
//             (master) and the up/down counter (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface udc_bus_sequencer_if;
    logic [7:0] bus_dout;
    logic       bus_oe;
    logic [7:0] bus_din;
    logic       ncs;
    logic       nrd;
    logic       nwr;
    logic [1:0] addr;
    logic       start_out;
    logic       ec_in;
    logic       err_in;

    modport master (
        output bus_dout, bus_oe, ncs, nrd, nwr, addr, start_out,
        input  bus_din, ec_in, err_in
    );

    modport slave (
        input  bus_dout, bus_oe, ncs, nrd, nwr, addr, start_out,
        output bus_din, ec_in, err_in
    );
endinterface
`default_nettype wire

// File: rtl/udc_bus_sequencer_timer.sv
`default_nettype none
// ============================================================================
//  Module   : udc_bus_timer
//  Purpose  : Loadable down-counter with zero flag; saturates at zero.
//  Revision : 1.0  initial release
// ============================================================================
module udc_bus_timer #(
    parameter int WIDTH = 20
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_load,
    input  wire logic             i_en,
    input  wire logic [WIDTH-1:0] i_load_val,
    output logic                  o_zero
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);
endmodule
`default_nettype wire

// File: rtl/udc_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : udc_bus_sequencer
//  Purpose  : Range-checks a counter configuration, programs it over the
//             register bus (optional read-back), starts and supervises a run.
//  Revision : 1.0  initial release
// ============================================================================
module udc_bus_sequencer
    import udc_pkg::*;
#(
    parameter int unsigned WR_PULSE = 2,
    parameter int unsigned VERIFY   = 1,
    parameter int unsigned TIMEOUT  = 20'hFFFFF
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic [7:0] cfg_plr,
    input  wire logic [7:0] cfg_ulr,
    input  wire logic [7:0] cfg_llr,
    input  wire logic [7:0] cfg_ccr,
    input  wire logic       go,
    udc_bus_sequencer_if.master bus,
    output logic            busy,
    output logic            done,
    output logic            fail,
    output logic [2:0]      fail_code
);
    localparam logic [c_TIMER_W-1:0] c_WR_LOAD  = c_TIMER_W'(WR_PULSE - 1);
    localparam logic [c_TIMER_W-1:0] c_RUN_LOAD = c_TIMER_W'(TIMEOUT - 1);

    state_t               r_state;
    logic [1:0]           r_idx;
    logic [7:0]           r_reg [4];
    logic                 w_tmr_load;
    logic                 w_tmr_en;
    logic                 w_tmr_zero;
    logic [c_TIMER_W-1:0] w_tmr_val;
    logic [1:0]           w_idx_nxt;
    logic                 w_range_ok;
    logic                 w_rd_match;
    logic                 w_ccr_zero;

    assign w_idx_nxt  = r_idx + 2'd1;
    assign w_range_ok = (r_reg[ADDR_LLR] <= r_reg[ADDR_PLR]) && (r_reg[ADDR_PLR] <= r_reg[ADDR_ULR]);
    assign w_rd_match = (bus.bus_din == r_reg[r_idx]);
    assign w_ccr_zero = (r_reg[ADDR_CCR] == 8'd0);

    // One timer serves both the write strobe width and the run watchdog
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_en   = 1'b0;
        w_tmr_val  = c_WR_LOAD;
        case (r_state)
            ST_WR_SETUP:          w_tmr_load = 1'b1;
            ST_START: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = c_RUN_LOAD;
            end
            ST_WR_STROBE, ST_RUN: w_tmr_en = 1'b1;
            default:              ;
        endcase
    end

    udc_bus_timer #(.WIDTH(c_TIMER_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_tmr_load),
        .i_en       (w_tmr_en),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    // Outputs are registered together with the state they belong to
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_idx         <= 2'd0;
            r_reg         <= '{default: 8'd0};
            bus.ncs       <= 1'b1;
            bus.nrd       <= 1'b1;
            bus.nwr       <= 1'b1;
            bus.bus_oe    <= 1'b0;
            bus.bus_dout  <= 8'd0;
            bus.addr      <= 2'd0;
            bus.start_out <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            fail          <= 1'b0;
            fail_code     <= FC_NONE;
        end else begin
            done          <= 1'b0;
            fail          <= 1'b0;
            bus.start_out <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (go) begin
                        r_reg     <= '{cfg_plr, cfg_ulr, cfg_llr, cfg_ccr};
                        fail_code <= FC_NONE;
                        busy      <= 1'b1;
                        r_state   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_range_ok) begin
                        r_idx        <= 2'd0;
                        bus.ncs      <= 1'b0;
                        bus.addr     <= ADDR_PLR;
                        bus.bus_dout <= r_reg[ADDR_PLR];
                        bus.bus_oe   <= 1'b1;
                        r_state      <= ST_WR_SETUP;
                    end else begin
                        fail_code <= FC_RANGE;
                        fail      <= 1'b1;
                        r_state   <= ST_FAIL;
                    end
                end
                ST_WR_SETUP: begin
                    bus.nwr <= 1'b0;
                    r_state <= ST_WR_STROBE;
                end
                ST_WR_STROBE: begin
                    if (w_tmr_zero) begin
                        bus.nwr <= 1'b1;
                        r_state <= ST_WR_HOLD;
                    end
                end
                ST_WR_HOLD: begin
                    if (r_idx != 2'd3) begin
                        r_idx        <= w_idx_nxt;
                        bus.addr     <= w_idx_nxt;
                        bus.bus_dout <= r_reg[w_idx_nxt];
                        r_state      <= ST_WR_SETUP;
                    end else if (VERIFY != 0) begin
                        r_idx      <= 2'd0;
                        bus.addr   <= ADDR_PLR;
                        bus.bus_oe <= 1'b0;
                        bus.nrd    <= 1'b0;
                        r_state    <= ST_RD_STROBE;
                    end else begin
                        bus.bus_oe <= 1'b0;
                        if (w_ccr_zero) begin
                            bus.ncs <= 1'b1;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            bus.start_out <= 1'b1;
                            r_state       <= ST_START;
                        end
                    end
                end
                ST_RD_STROBE: r_state <= ST_RD_SAMPLE;
                ST_RD_SAMPLE: begin
                    if (!w_rd_match) begin
                        fail_code <= FC_READBACK;
                        fail      <= 1'b1;
                        bus.ncs   <= 1'b1;
                        bus.nrd   <= 1'b1;
                        r_state   <= ST_FAIL;
                    end else if (r_idx != 2'd3) begin
                        r_idx    <= w_idx_nxt;
                        bus.addr <= w_idx_nxt;
                        r_state  <= ST_RD_STROBE;
                    end else begin
                        bus.nrd <= 1'b1;
                        // CCR of zero is a no-op on the counter, so no run is started
                        if (w_ccr_zero) begin
                            bus.ncs <= 1'b1;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            bus.start_out <= 1'b1;
                            r_state       <= ST_START;
                        end
                    end
                end
                ST_START: r_state <= ST_RUN;
                ST_RUN: begin
                    if (bus.ec_in) begin
                        bus.ncs <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (bus.err_in || w_tmr_zero) begin
                        fail_code <= bus.err_in ? FC_COUNTER : FC_TIMEOUT;
                        fail      <= 1'b1;
                        bus.ncs   <= 1'b1;
                        r_state   <= ST_FAIL;
                    end
                end
                ST_FAIL: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_udc_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_udc_bus_sequencer
//  Purpose  : Scoreboard bench for udc_bus_sequencer with a counter slave model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_udc_bus_sequencer;
    localparam int WP  = 2;
    localparam int TMO = 100;
    localparam int WB  = 2 + 4 * (WP + 2);   // first read cycle after go

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] cfg_plr, cfg_ulr, cfg_llr, cfg_ccr;
    logic       go;
    logic       busy, done, fail;
    logic [2:0] fail_code;

    udc_bus_sequencer_if bus ();

    udc_bus_sequencer #(.WR_PULSE(WP), .VERIFY(1), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_plr   (cfg_plr),
        .cfg_ulr   (cfg_ulr),
        .cfg_llr   (cfg_llr),
        .cfg_ccr   (cfg_ccr),
        .go        (go),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_code (fail_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Counter slave: register file written by the bus, read back with an optional corruption
    logic [7:0] mem [4];
    logic       ovr_en;
    logic [1:0] ovr_addr;
    logic [7:0] ovr_val;

    always @(posedge clk)
        if (!reset && !bus.ncs && !bus.nwr) mem[bus.addr] <= bus.bus_dout;

    assign bus.bus_din = !bus.nrd ? ((ovr_en && bus.addr == ovr_addr) ? ovr_val : mem[bus.addr]) : 8'h00;

    logic [9:0] exp_wr_q [$];
    logic [3:0] exp_res_q [$];
    bit         in_wr = 1'b0;
    int         wr_w = 0;
    int         n_starts = 0;

    always @(negedge clk) begin
        logic [9:0] ew;
        logic [3:0] er;
        if (reset) begin
            in_wr = 1'b0;
        end else begin
            chk("rd_wr_excl", {31'd0, ~bus.nrd & ~bus.nwr}, 0);
            chk("oe_rule", {31'd0, bus.bus_oe & (bus.ncs | ~bus.nrd)}, 0);
            chk("ncs_busy", {31'd0, ~bus.ncs & ~busy}, 0);
            if (!bus.nwr) begin
                if (!in_wr) begin
                    in_wr = 1'b1;
                    wr_w  = 1;
                    if (exp_wr_q.size() == 0) begin
                        chk("wr_expected", exp_wr_q.size(), 1);
                    end else begin
                        ew = exp_wr_q.pop_front();
                        chk("wr_addr", bus.addr, ew[9:8]);
                        chk("wr_data", bus.bus_dout, ew[7:0]);
                        chk("wr_oe", bus.bus_oe, 1);
                    end
                end else begin
                    wr_w++;
                end
            end else if (in_wr) begin
                in_wr = 1'b0;
                chk("wr_width", wr_w, WP);
            end
            if (bus.start_out) n_starts++;
            if (done || fail) begin
                if (exp_res_q.size() == 0) begin
                    chk("res_expected", exp_res_q.size(), 1);
                end else begin
                    er = exp_res_q.pop_front();
                    chk("result", {done, fail, fail_code}, {~er[3], er[3], er[2:0]});
                end
            end
        end
    end

    // mode: 0 ec, 1 err, 2 neither (timeout), 3 ec and err together
    task automatic txn(input logic [7:0] p, u, l, cc, input bit oen, input logic [1:0] oa,
                       input logic [7:0] ov, input int mode, input int dly);
        logic [7:0] regs [4];
        logic [3:0] res;
        int exp_end, exp_st, mis, c, cs;
        bit started, fin;
        regs   = '{p, u, l, cc};
        exp_st = 0;
        if (!(l <= p && p <= u)) begin
            res     = 4'b1_001;
            exp_end = 2;
        end else begin
            for (int i = 0; i < 4; i++) exp_wr_q.push_back({2'(i), regs[i]});
            mis = -1;
            for (int i = 0; i < 4; i++)
                if (mis < 0 && oen && int'(oa) == i && ov != regs[i]) mis = i;
            if (mis >= 0) begin
                res     = 4'b1_010;
                exp_end = WB + 2 * mis + 2;
            end else if (cc == 8'd0) begin
                res     = 4'b0_000;
                exp_end = WB + 8;
            end else begin
                exp_st  = 1;
                exp_end = WB + 8 + ((mode == 2) ? TMO : dly) + 1;
                res     = (mode == 1) ? 4'b1_011 : (mode == 2) ? 4'b1_100 : 4'b0_000;
            end
        end
        exp_res_q.push_back(res);

        @(posedge clk); #1;
        ovr_en = oen; ovr_addr = oa; ovr_val = ov;
        cfg_plr = p; cfg_ulr = u; cfg_llr = l; cfg_ccr = cc;
        go = 1'b1;
        n_starts = 0;
        c = 0; cs = 0; started = 1'b0; fin = 1'b0;
        while (!fin && c < 400) begin
            @(posedge clk); #1;
            c++;
            go = (c == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (c == 1) begin
                cfg_plr = 8'($urandom); cfg_ulr = 8'($urandom);
                cfg_llr = 8'($urandom); cfg_ccr = 8'($urandom);
            end
            bus.ec_in  = started && (mode == 0 || mode == 3) && (c - cs) == dly;
            bus.err_in = started && (mode == 1 || mode == 3) && (c - cs) == dly;
            @(negedge clk);
            if (bus.start_out && !started) begin
                started = 1'b1;
                cs = c;
            end
            if (done || fail) fin = 1'b1;
        end
        chk("end_cycle", fin ? c : 9999, exp_end);
        if (exp_st != 0) chk("start_cycle", cs, WB + 8);
        @(posedge clk); #1;
        bus.ec_in = 1'b0; bus.err_in = 1'b0; go = 1'b0;
        @(negedge clk);
        chk("start_count", n_starts, exp_st);
        chk("fail_code_held", fail_code, res[2:0]);
        chk("busy_after", busy, 0);
        chk("ncs_after", bus.ncs, 1);
        chk("wr_q_left", exp_wr_q.size(), 0);
        chk("res_q_left", exp_res_q.size(), 0);
        exp_wr_q.delete();
        exp_res_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ncs"}, bus.ncs, 1);
        chk({tag, "_nrd"}, bus.nrd, 1);
        chk({tag, "_nwr"}, bus.nwr, 1);
        chk({tag, "_oe"}, bus.bus_oe, 0);
        chk({tag, "_dout"}, bus.bus_dout, 0);
        chk({tag, "_addr"}, bus.addr, 0);
        chk({tag, "_start"}, bus.start_out, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done_fail"}, {done, fail}, 0);
        chk({tag, "_fail_code"}, fail_code, 0);
    endtask

    task automatic reset_mid_write();
        int c;
        bit found;
        exp_wr_q.push_back({2'd0, 8'd5});
        exp_wr_q.push_back({2'd1, 8'd10});
        @(posedge clk); #1;
        ovr_en = 1'b0;
        cfg_plr = 8'd5; cfg_ulr = 8'd10; cfg_llr = 8'd2; cfg_ccr = 8'd2;
        go = 1'b1;
        c = 0; found = 1'b0;
        while (!found && c < 50) begin
            @(posedge clk); #1;
            go = 1'b0;
            c++;
            @(negedge clk);
            found = !bus.nwr && bus.addr == 2'd1;
        end
        chk("reached_ulr_strobe", found, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        exp_wr_q.delete();
        exp_res_q.delete();
    endtask

    initial begin
        logic [7:0] p, u, l, cc, t;
        logic [7:0] rr [4];
        logic [1:0] oa;
        reset = 1'b1; go = 1'b0;
        bus.ec_in = 1'b0; bus.err_in = 1'b0;
        ovr_en = 1'b0; ovr_addr = 2'd0; ovr_val = 8'd0;
        cfg_plr = 8'd0; cfg_ulr = 8'd0; cfg_llr = 8'd0; cfg_ccr = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        txn(8'd5,  8'd10, 8'd2, 8'd2, 1'b0, 2'd0, 8'h00, 0, 40);   // nominal
        txn(8'd12, 8'd10, 8'd2, 8'd2, 1'b0, 2'd0, 8'h00, 0, 5);    // range error
        txn(8'd5,  8'd10, 8'd2, 8'd2, 1'b1, 2'd0, 8'h07, 0, 5);    // PLR read-back mismatch
        txn(8'd5,  8'd10, 8'd2, 8'd0, 1'b0, 2'd0, 8'h00, 0, 5);    // CCR zero
        txn(8'd5,  8'd10, 8'd2, 8'd2, 1'b0, 2'd0, 8'h00, 2, 0);    // timeout
        txn(8'd5,  8'd10, 8'd2, 8'd2, 1'b0, 2'd0, 8'h00, 3, 10);   // ec and err together
        txn(8'd5,  8'd10, 8'd2, 8'd2, 1'b0, 2'd0, 8'h00, 1, 5);    // counter error
        txn(8'd7,  8'd7,  8'd7, 8'd1, 1'b1, 2'd3, 8'h81, 0, 1);    // equal limits, CCR mismatch
        txn(8'd0,  8'd255, 8'd0, 8'd255, 1'b0, 2'd0, 8'h00, 0, 3); // full range
        txn(8'd200, 8'd255, 8'd201, 8'd3, 1'b0, 2'd0, 8'h00, 0, 3);// plr just below llr
        reset_mid_write();
        txn(8'd5,  8'd10, 8'd2, 8'd2, 1'b0, 2'd0, 8'h00, 0, 20);

        for (int n = 0; n < 25; n++) begin
            l = 8'($urandom); u = 8'($urandom);
            if (u < l) begin t = u; u = l; l = t; end
            if ($urandom_range(0, 4) == 0) p = 8'($urandom);
            else p = 8'(int'(l) + int'($urandom % (int'(u) - int'(l) + 1)));
            cc = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
            rr = '{p, u, l, cc};
            oa = 2'($urandom);
            txn(p, u, l, cc, $urandom_range(0, 5) == 0, oa, rr[oa] ^ 8'($urandom_range(1, 255)),
                int'($urandom_range(0, 3)), int'($urandom_range(1, 60)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/udc_bus_sequencer.md
Name: udc_bus_sequencer

Overview:
- Upstream host-side controller for the 8-bit up/down counter's register bus.
- Takes one counter configuration (PLR, ULR, LLR, CCR) in parallel and range-checks it.
- Programs the configuration through four bus write cycles with optional read-back verify, then issues the start pulse.
- Holds chip select active while the counter runs, waits for end-of-cycle, and reports done or a failure code to the system controller.

Parameters:
- WR_PULSE, 2: number of clk cycles nwr is held low per write (1..15).
- VERIFY, 1: 1 = read back all four registers after writing and compare; 0 = skip read-back.
- TIMEOUT, 20'hFFFFF: maximum number of clk cycles spent in RUN before failing with a timeout.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- cfg_plr  in  8  preload value.
- cfg_ulr  in  8  upper limit.
- cfg_llr  in  8  lower limit.
- cfg_ccr  in  8  cycle count.
- go  in  1  request strobe; sampled only in IDLE.
- bus_dout  out  8  write data driven onto counter Din.
- bus_oe  out  1  1 = drive Din (tri-state enable for the top-level pad).
- bus_din  in  8  Din as seen during reads.
- ncs  out  1  counter chip select, active-low.
- nrd  out  1  read strobe, active-low.
- nwr  out  1  write strobe, active-low.
- addr  out  2  {A1,A0} register select: 00 PLR, 01 ULR, 10 LLR, 11 CCR.
- start_out  out  1  counter start_in.
- ec_in  in  1  counter end-cycle flag.
- err_in  in  1  counter range-error flag.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- fail  out  1  one-cycle pulse on failure.
- fail_code  out  3  0 none, 1 range, 2 readback mismatch, 3 counter error, 4 timeout; held until the next go.

Behaviour:
- Reset values: ncs=1, nrd=1, nwr=1, bus_oe=0, bus_dout=0, addr=0, start_out=0, busy=0, done=0, fail=0, fail_code=0, state=IDLE.
- Reset mid-operation returns to IDLE within one cycle; all outputs take their reset values.
- Bus exclusivity: nrd and nwr are never low in the same cycle. bus_oe=1 only while nwr=0 or in WR_SETUP/WR_HOLD.
- IDLE: when go=1, latch cfg_* into internal copies, clear fail_code, go to CHECK. go is ignored while busy.
- CHECK (1 cycle): if llr<=plr<=ulr, go to WR_SETUP with idx=0. Otherwise fail_code=1 and go to FAIL. The comparison is unsigned 8-bit.
- WR_SETUP (1 cycle): ncs=0, addr=idx, bus_dout=reg[idx], bus_oe=1, nwr=1.
- WR_STROBE (WR_PULSE cycles): nwr=0; addr and data stable.
- WR_HOLD (1 cycle): nwr=1, data held. Then idx+1 → WR_SETUP. After idx=3, go to RD_STROBE (VERIFY=1) or START (VERIFY=0).
- Write cost: WR_PULSE+2 cycles per register.
- RD_STROBE (1 cycle): nrd=0, bus_oe=0, addr=idx.
- RD_SAMPLE (1 cycle): nrd=0; compare bus_din with reg[idx]. On mismatch: fail_code=2, go to FAIL. On match: idx+1; after idx=3 go to START.
- START: if ccr==0, skip start, pulse done, go to IDLE (the counter treats CCR=0 as no-op). Otherwise start_out=1 for exactly 1 cycle, then RUN.
- RUN: ncs stays 0; nrd=nwr=1; a 20-bit cycle counter runs.
  - ec_in=1: pulse done, go to IDLE.
  - err_in=1: fail_code=3, go to FAIL.
  - Counter reaches TIMEOUT: fail_code=4, go to FAIL.
  - Priority when simultaneous: ec_in > err_in > timeout.
- FAIL (1 cycle): fail=1, ncs=1, then IDLE.
- ncs returns to 1 in IDLE.
- Exactly one of done or fail pulses per accepted go.

Decomposition:
- Shared package udc_pkg:
  - Register address constants ADDR_PLR/ULR/LLR/CCR.
  - fail_code enum values.
  - State enum.
- One sub-module, udc_bus_timer: loadable down-counter reused for the WR_PULSE strobe width and the RUN timeout, with load, en, and zero flag.

Test Plan:
- Nominal: plr=5, ulr=10, llr=2, ccr=2, VERIFY=1 → four writes with data 05/0A/02/02 at addresses 00/01/10/11, nwr low for 2 cycles each. Read-back matches; start_out high for 1 cycle. ec_in asserted 40 cycles later → done pulse, busy=0, ncs=1.
- Range error: plr=12, ulr=10, llr=2 → no bus activity (ncs stays 1); fail pulse 2 cycles after go; fail_code=1.
- Read-back mismatch: bench model returns 0x07 for PLR read → fail, fail_code=2, start_out never asserted.
- ccr=0 → writes complete, no start_out, done pulse right after the last write or read.
- Timeout/error: TIMEOUT=100 with ec_in held 0 → fail_code=4 at RUN cycle 100. A second run with err_in=1 and ec_in=1 in the same cycle → done, fail_code=0.
- Reset mid-write: assert reset during WR_STROBE of ULR → next cycle ncs=nwr=1, bus_oe=0, busy=0. A new go then restarts from PLR.
